// File: rtl/phosphorus_vga_pkg.sv
// Shared types and defaults for the phosphorus VGA display-side blocks.
package phosphorus_vga_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      COMMIT  = 2'd2
   } swap_state_e;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_CNT_W       = 16;
   localparam int HOLD_W          = 4;

   localparam logic [HOLD_W-1:0] HOLD_MAX = '1;

endpackage

// File: rtl/cdc_toggle_sync.sv
// Brings a toggle from another clock domain across, then emits one registered
// single-cycle event per toggle.
module cdc_toggle_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_tgl,
   output logic o_evt
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   edge_q, edge_d;
   logic                   evt_q, evt_d;

   // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], i_tgl};
      edge_d = sync_q[SYNC_STAGES-1];
      evt_d  = sync_q[SYNC_STAGES-1] ^ edge_q;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         edge_q <= 1'b0;
         evt_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         edge_q <= edge_d;
         evt_q  <= evt_d;
      end
   end

   assign o_evt = evt_q;

endmodule

// File: rtl/vga_frame_swap_ctrl.sv
// Front/back framebuffer swap controller; commits swaps only at vsync fall.
// Define VGA_FRAME_STATS_EN to add the o_frame_cnt / o_repeat_cnt statistics ports.
module vga_frame_swap_ctrl
   import phosphorus_vga_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int MIN_HOLD_FRAMES = 1,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic             clk_vga,
   input  logic             reset_n,
   input  logic             i_vs,
   input  logic             i_render_done_tgl,
   output logic             o_front_sel,
   output logic             o_swap_ack_tgl,
   output logic             o_vblank_pulse,
   output logic             o_pending,
   output logic             o_overrun
`ifdef VGA_FRAME_STATS_EN
   ,
   output logic [CNT_W-1:0] o_frame_cnt,
   output logic [CNT_W-1:0] o_repeat_cnt
`endif
);

   // Starting the hold count at the threshold lets the first swap after reset go at once.
   localparam logic [HOLD_W-1:0] HOLD_RST = HOLD_W'(MIN_HOLD_FRAMES - 1);

   swap_state_e       state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              vs_q, vs_d;
   logic              front_q, front_d;
   logic              ack_q, ack_d;
   logic              vblank_q, vblank_d;
   logic              pending_q, pending_d;
   logic              overrun_q, overrun_d;
   logic              vs_fall;
   logic              rd_evt;
   logic              hold_ok;
   logic              commit;

   cdc_toggle_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_rd_sync (
      .clk     (clk_vga),
      .reset_n (reset_n),
      .i_tgl   (i_render_done_tgl),
      .o_evt   (rd_evt)
   );

   assign vs_fall = vs_q & ~i_vs;
   assign hold_ok = int'(hold_q) >= (MIN_HOLD_FRAMES - 1);
   assign commit  = (state_q == PENDING) && vs_fall && hold_ok;

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      vs_d      = i_vs;
      front_d   = front_q;
      ack_d     = ack_q;
      vblank_d  = vs_fall;
      overrun_d = overrun_q;

      if (vs_fall && (state_q != COMMIT) && (hold_q != HOLD_MAX)) begin
         hold_d = hold_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (rd_evt) state_d = PENDING;
         end
         PENDING: begin
            // A second render event before the ack is flagged, never queued.
            if (rd_evt) overrun_d = 1'b1;
            if (commit) begin
               state_d = COMMIT;
               front_d = ~front_q;
               ack_d   = ~ack_q;
               hold_d  = '0;
            end
         end
         COMMIT: begin
            if (rd_evt) overrun_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      pending_d = (state_d == PENDING);
   end

   // vs_q resets low so a reset released mid-vsync does not count a partial frame.
   always_ff @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         hold_q    <= HOLD_RST;
         vs_q      <= 1'b0;
         front_q   <= 1'b0;
         ack_q     <= 1'b0;
         vblank_q  <= 1'b0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         vs_q      <= vs_d;
         front_q   <= front_d;
         ack_q     <= ack_d;
         vblank_q  <= vblank_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign o_front_sel    = front_q;
   assign o_swap_ack_tgl = ack_q;
   assign o_vblank_pulse = vblank_q;
   assign o_pending      = pending_q;
   assign o_overrun      = overrun_q;

`ifdef VGA_FRAME_STATS_EN
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] repeat_cnt_q, repeat_cnt_d;

   // Both counters wrap freely; a repeat is any vsync fall that did not swap.
   always_comb begin
      frame_cnt_d  = frame_cnt_q + CNT_W'(vs_fall);
      repeat_cnt_d = repeat_cnt_q + CNT_W'(vs_fall & ~commit);
   end

   always_ff @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt_q  <= '0;
         repeat_cnt_q <= '0;
      end else begin
         frame_cnt_q  <= frame_cnt_d;
         repeat_cnt_q <= repeat_cnt_d;
      end
   end

   assign o_frame_cnt  = frame_cnt_q;
   assign o_repeat_cnt = repeat_cnt_q;
`endif

endmodule

// File: tb/tb_vga_frame_swap_ctrl.sv
// Scoreboard bench for vga_frame_swap_ctrl: two instances (MIN_HOLD 1 and 3)
// driven by randomized render toggles against a frame-level reference model.
module tb_vga_frame_swap_ctrl;

   localparam int FRAME_LEN = 24;
   localparam int VS_LEN    = 3;
   localparam int S_A       = 2;
   localparam int M_A       = 1;
   localparam int S_B       = 3;
   localparam int M_B       = 3;
   localparam int CNT_W     = 16;

   typedef struct {
      int at_edge;
      bit front;
      bit ack;
      bit pending;
      bit overrun;
      int frames;
      int repeats;
   } sb_t;

   logic       clk_vga = 1'b0;
   logic       reset_n;
   logic       i_vs;
   logic [1:0] tgl;
   logic [1:0] front_sel, ack, vblank, pending, overrun;
`ifdef VGA_FRAME_STATS_EN
   logic [1:0][CNT_W-1:0] frame_cnt, repeat_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: what the display should be showing, tracked per frame.
   bit  m_front[2], m_ack[2], m_wait[2], m_ovr[2];
   int  m_shown[2], m_frames[2], m_repeat[2], m_last_swap[2];
   int  fall_q[$];
   int  arr_q[2][$];
   sb_t sb_q[2][$];

   always #5 clk_vga = ~clk_vga;

   vga_frame_swap_ctrl #(
      .SYNC_STAGES(S_A), .MIN_HOLD_FRAMES(M_A), .CNT_W(CNT_W)
   ) dut_a (
      .clk_vga           (clk_vga),
      .reset_n           (reset_n),
      .i_vs              (i_vs),
      .i_render_done_tgl (tgl[0]),
      .o_front_sel       (front_sel[0]),
      .o_swap_ack_tgl    (ack[0]),
      .o_vblank_pulse    (vblank[0]),
      .o_pending         (pending[0]),
      .o_overrun         (overrun[0])
`ifdef VGA_FRAME_STATS_EN
      ,
      .o_frame_cnt       (frame_cnt[0]),
      .o_repeat_cnt      (repeat_cnt[0])
`endif
   );

   vga_frame_swap_ctrl #(
      .SYNC_STAGES(S_B), .MIN_HOLD_FRAMES(M_B), .CNT_W(CNT_W)
   ) dut_b (
      .clk_vga           (clk_vga),
      .reset_n           (reset_n),
      .i_vs              (i_vs),
      .i_render_done_tgl (tgl[1]),
      .o_front_sel       (front_sel[1]),
      .o_swap_ack_tgl    (ack[1]),
      .o_vblank_pulse    (vblank[1]),
      .o_pending         (pending[1]),
      .o_overrun         (overrun[1])
`ifdef VGA_FRAME_STATS_EN
      ,
      .o_frame_cnt       (frame_cnt[1]),
      .o_repeat_cnt      (repeat_cnt[1])
`endif
   );

   function automatic int stages(input int x);
      return (x == 0) ? S_A : S_B;
   endfunction

   function automatic int min_hold(input int x);
      return (x == 0) ? M_A : M_B;
   endfunction

   task automatic check(input string name, input int x, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cyc=%0d actual=%0h expected=%0h", name, x, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int x = 0; x < 2; x++) begin
         m_front[x]     = 1'b0;
         m_ack[x]       = 1'b0;
         m_wait[x]      = 1'b0;
         m_ovr[x]       = 1'b0;
         m_shown[x]     = 1000;
         m_frames[x]    = 0;
         m_repeat[x]    = 0;
         m_last_swap[x] = -10;
         arr_q[x].delete();
         sb_q[x].delete();
      end
      fall_q.delete();
   endtask

   // One clock edge of the model: a vsync fall shows a new buffer if one is
   // waiting and the current one has been up long enough; a render event that
   // lands while a frame already waits, or on the swap cycle, is an overrun.
   task automatic model_edge(input int x, input bit fall);
      bit  was_waiting;
      bit  arr;
      sb_t e;
      was_waiting = m_wait[x];
      arr = 1'b0;
      if (arr_q[x].size() != 0 && arr_q[x][0] == cyc) begin
         arr = 1'b1;
         void'(arr_q[x].pop_front());
      end
      if (fall) begin
         m_frames[x]++;
         m_shown[x]++;
         if (m_wait[x] && m_shown[x] >= min_hold(x)) begin
            m_front[x]     = ~m_front[x];
            m_ack[x]       = ~m_ack[x];
            m_wait[x]      = 1'b0;
            m_shown[x]     = 0;
            m_last_swap[x] = cyc;
         end else begin
            m_repeat[x]++;
         end
      end
      if (arr) begin
         if (was_waiting || cyc == m_last_swap[x] + 1) m_ovr[x] = 1'b1;
         else m_wait[x] = 1'b1;
      end
      if (fall) begin
         e.at_edge = cyc;
         e.front   = m_front[x];
         e.ack     = m_ack[x];
         e.pending = m_wait[x];
         e.overrun = m_ovr[x];
         e.frames  = m_frames[x];
         e.repeats = m_repeat[x];
         sb_q[x].push_back(e);
      end
   endtask

   initial begin
      bit fall;
      forever begin
         @(posedge clk_vga);
         cyc++;
         if (reset_n === 1'b1) begin
            fall = (fall_q.size() != 0 && fall_q[0] == cyc);
            if (fall) void'(fall_q.pop_front());
            for (int x = 0; x < 2; x++) model_edge(x, fall);
         end
      end
   end

   // Monitor: per-cycle state compare, and a scoreboard pop on each vblank pulse.
   initial begin
      sb_t e;
      bit  exp_pulse;
      forever begin
         @(negedge clk_vga);
         if (reset_n === 1'b1) begin
            for (int x = 0; x < 2; x++) begin
               check("front_sel", x, 32'(front_sel[x]), 32'(m_front[x]));
               check("swap_ack", x, 32'(ack[x]), 32'(m_ack[x]));
               check("pending", x, 32'(pending[x]), 32'(m_wait[x]));
               check("overrun", x, 32'(overrun[x]), 32'(m_ovr[x]));
               exp_pulse = (sb_q[x].size() != 0 && sb_q[x][0].at_edge == cyc);
               check("vblank_pulse", x, 32'(vblank[x]), 32'(exp_pulse));
               if (exp_pulse) begin
                  e = sb_q[x].pop_front();
                  check("vb_front", x, 32'(front_sel[x]), 32'(e.front));
                  check("vb_ack", x, 32'(ack[x]), 32'(e.ack));
                  check("vb_pending", x, 32'(pending[x]), 32'(e.pending));
                  check("vb_overrun", x, 32'(overrun[x]), 32'(e.overrun));
`ifdef VGA_FRAME_STATS_EN
                  check("frame_cnt", x, 32'(frame_cnt[x]), 32'(e.frames & 'hFFFF));
                  check("repeat_cnt", x, 32'(repeat_cnt[x]), 32'(e.repeats & 'hFFFF));
`endif
               end
            end
         end
      end
   end

   function automatic bit can_toggle(input int x);
      return !m_wait[x] && arr_q[x].size() == 0;
   endfunction

   task automatic do_toggle(input int x);
      tgl[x] = ~tgl[x];
      arr_q[x].push_back(cyc + stages(x) + 2);
   endtask

   task automatic check_all_zero(input string tag);
      for (int x = 0; x < 2; x++) begin
         check({tag, "_front"}, x, 32'(front_sel[x]), 0);
         check({tag, "_ack"}, x, 32'(ack[x]), 0);
         check({tag, "_vblank"}, x, 32'(vblank[x]), 0);
         check({tag, "_pending"}, x, 32'(pending[x]), 0);
         check({tag, "_overrun"}, x, 32'(overrun[x]), 0);
`ifdef VGA_FRAME_STATS_EN
         check({tag, "_frame_cnt"}, x, 32'(frame_cnt[x]), 0);
         check({tag, "_repeat_cnt"}, x, 32'(repeat_cnt[x]), 0);
`endif
      end
   endtask

   // One display frame. Offsets are cycles after the vsync-fall drive point;
   // -1 means no toggle. A toggle is only issued once the previous frame was
   // acked, unless forced. rst_at >= 0 pulses reset_n inside the frame.
   task automatic run_frame(input int off_a, input int off_b, input bit force_a,
                            input bit force_b, input bit dbl_a, input int rst_at);
      for (int j = 0; j < FRAME_LEN; j++) begin
         @(posedge clk_vga);
         #1;
         if (j == 0) begin
            i_vs = 1'b0;
            fall_q.push_back(cyc + 1);
         end
         if (j == VS_LEN) i_vs = 1'b1;
         if (j == off_a && (force_a || can_toggle(0))) do_toggle(0);
         if (j == off_b && (force_b || can_toggle(1))) do_toggle(1);
         if (dbl_a && j == off_a + 4) do_toggle(0);
         if (j == rst_at) begin
            #1;
            reset_n = 1'b0;
            tgl     = 2'b00;
            #1;
            check_all_zero("async_rst");
            model_reset();
         end
         if (rst_at >= 0 && j == rst_at + 2) reset_n = 1'b1;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      i_vs    = 1'b1;
      tgl     = 2'b00;
      model_reset();
      repeat (3) @(posedge clk_vga);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;

      // Idle frames: one vblank per frame, no swap, repeats accumulate.
      repeat (3) run_frame(-1, -1, 1'b0, 1'b0, 1'b0, -1);

      // Single mid-frame render toggle on each instance.
      run_frame(10, 10, 1'b0, 1'b0, 1'b0, -1);
      run_frame(-1, -1, 1'b0, 1'b0, 1'b0, -1);

      // Randomized render pacing; dut_b renders every frame it is allowed to.
      for (int k = 0; k < 16; k++) begin
         int oa, ob;
         oa = ($urandom_range(0, 9) < 7) ? int'($urandom_range(VS_LEN + 2, FRAME_LEN - S_A - 3)) : -1;
         ob = int'($urandom_range(VS_LEN + 2, FRAME_LEN - S_B - 3));
         run_frame(oa, ob, 1'b0, 1'b0, 1'b0, -1);
      end

      // Render event lands on the same edge as the vsync fall.
      repeat (3) run_frame(FRAME_LEN - S_A - 1, FRAME_LEN - S_B - 1, 1'b0, 1'b0, 1'b0, -1);
      repeat (3) run_frame(-1, -1, 1'b0, 1'b0, 1'b0, -1);

      // Second toggle before the ack on dut_a.
      run_frame(8, -1, 1'b1, 1'b0, 1'b1, -1);
      repeat (2) run_frame(6, -1, 1'b0, 1'b0, 1'b0, -1);

      // Reset while dut_a shows buffer 1 with a frame pending.
      for (int k = 0; k < 8; k++) begin
         if (m_front[0] && can_toggle(0)) break;
         run_frame(6, -1, 1'b0, 1'b0, 1'b0, -1);
      end
      run_frame(6, -1, 1'b0, 1'b0, 1'b0, 16);
      repeat (2) run_frame(-1, -1, 1'b0, 1'b0, 1'b0, -1);

      repeat (4) @(posedge clk_vga);
      #1;
      for (int x = 0; x < 2; x++) check("sb_drained", x, 32'(sb_q[x].size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_frame_swap_ctrl.md
# vga_frame_swap_ctrl

Double-buffer swap controller on the display clock. It sits directly beside `VGADriver`, taking that block's active-low vertical sync (`oVs`) and a per-frame render-complete toggle from the SM render side on `clk`. It commits a front/back framebuffer swap only at the start of vertical sync, so a frame is never torn. Its `o_front_sel` drives the buffer-select MSB of the framebuffer read address, and `o_swap_ack_tgl` returns to the render side to release the next frame.

## Interface
- SYNC_STAGES, 2: flops in the `i_render_done_tgl` synchronizer; legal 2..4.
- MIN_HOLD_FRAMES, 1: minimum vsync falls a front buffer is shown before it can be replaced; legal 1..15; this is the frame-rate cap.
- CNT_W, 16: width of the statistics counters.
- clk_vga  in  1  display pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_vs  in  1  active-low vsync, synchronous to clk_vga; may be combinational upstream.
- i_render_done_tgl  in  1  clk domain; toggles once per frame fully written to the back buffer.
- o_front_sel  out  1  buffer being displayed; back buffer is ~o_front_sel.
- o_swap_ack_tgl  out  1  toggles once per committed swap.
- o_vblank_pulse  out  1  one-cycle pulse per vsync falling edge.
- o_pending  out  1  a rendered frame is waiting for a swap.
- o_overrun  out  1  sticky; set on a protocol violation.
- o_frame_cnt  out  CNT_W  vsync falls since reset; present only with the stats macro.
- o_repeat_cnt  out  CNT_W  vsync falls with no swap, i.e. the previous frame was shown again; present only with the stats macro.

## Operation
- Input conditioning:
  - `i_vs` is registered once into `vs_q`; `vs_fall = vs_q & ~i_vs`.
  - `i_render_done_tgl` passes through SYNC_STAGES flops, then one edge-detect flop; `rd_evt` is high for one cycle per input toggle.
- FSM states:
  - IDLE: no frame waiting.
  - PENDING: a frame is waiting.
  - COMMIT: a transient single cycle.
- FSM transitions:
  - IDLE → PENDING on `rd_evt`.
  - PENDING → COMMIT on `vs_fall` when `hold_cnt >= MIN_HOLD_FRAMES-1`.
  - COMMIT → IDLE unconditionally.
- COMMIT actions: flip `o_front_sel`, flip `o_swap_ack_tgl`, clear `hold_cnt` to 0.
- hold_cnt:
  - Width 4; increments on each `vs_fall` outside COMMIT, saturating at 15.
  - Reset value is MIN_HOLD_FRAMES-1, so the first swap after reset is not delayed.
- Simultaneous `rd_evt` and `vs_fall` in IDLE: go to PENDING with no commit this frame; the earliest commit is the next `vs_fall`.
- `rd_evt` while in PENDING or COMMIT: the render side did not wait for ack.
  - Set `o_overrun`; the event is otherwise ignored.
  - The state is unchanged and only one swap is pending.
- `o_pending` is high exactly in PENDING.
- `o_vblank_pulse` is the registered `vs_fall`.
- Reset mid-operation:
  - All state returns to reset values; any pending swap is discarded.
  - The render side must be reset together with this block so that the toggle parities match (both 0).

## Timing
- Reset values: `o_front_sel`=0, `o_swap_ack_tgl`=0, `o_vblank_pulse`=0, `o_pending`=0, `o_overrun`=0, counters=0, FSM=IDLE.
- Render toggle to `o_pending`: SYNC_STAGES+2 clk_vga edges.
- Vsync:
  - First `i_vs`=0 sample at edge N gives `vs_fall` in cycle N.
  - `o_vblank_pulse` is high in cycle N+1.
- Swap timing: `o_front_sel` and `o_swap_ack_tgl` change at edge N+1, coincident with `o_vblank_pulse`. This is well inside the 23-line back porch; the read side sees the new buffer for the whole next active frame.
- `o_front_sel` changes only at that edge and never mid-frame.
- Counter arithmetic: counters increment at edge N+1; they wrap modulo 2^CNT_W without saturating.

## Configuration
- VGA_FRAME_STATS_EN defined:
  - `o_frame_cnt` increments on every `vs_fall`.
  - `o_repeat_cnt` increments on every `vs_fall` that does not cause COMMIT.
- Undefined: both ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package `phosphorus_vga_pkg`:
  - FSM state enum (IDLE, PENDING, COMMIT).
  - Default constants for SYNC_STAGES, CNT_W, and the 4-bit hold width.
- One sub-module, `cdc_toggle_sync`:
  - Parameter SYNC_STAGES; async active-low reset.
  - Toggle in, single-cycle event pulse out.
  - Reusable for other clk→clk_vga toggles.

## Test plan
- Reset release:
  - All outputs are 0; several vsyncs with no render toggle.
  - Required response: `o_vblank_pulse` once per frame, `o_front_sel` stays 0, `o_repeat_cnt`=3 after 3 frames.
- Single render toggle mid-frame:
  - `o_pending`=1 after SYNC_STAGES+2 cycles.
  - At the next vsync fall, `o_front_sel` 0→1 and `o_swap_ack_tgl` 0→1 in the same cycle as `o_vblank_pulse`; `o_pending`→0.
- MIN_HOLD_FRAMES=3:
  - Render toggles arrive every frame, each only after ack.
  - Swaps occur exactly every 3rd vsync fall; `o_repeat_cnt` grows by 2 per swap.
- Toggle on the vsync-fall cycle:
  - Arrange `rd_evt` and `vs_fall` in the same cycle in IDLE.
  - Required response: no swap that frame; swap at the following fall.
- Second toggle before ack:
  - `o_overrun`=1 and stays 1.
  - Exactly one swap occurs; toggle parity still consistent afterwards.
- `reset_n` asserted while PENDING, with `o_front_sel`=1:
  - All outputs return to 0 immediately (asynchronously).
  - No swap occurs at the next vsync.
